// File: rtl/event_window_counter.sv
// event_window_counter
//   Counts detection pulses over back-to-back windows of WINDOW clock cycles.
//   Raises a one-cycle alarm when the in-window count reaches THRESH, and
//   publishes each completed window's count on a valid/ready report port.
//   A report that is overwritten before being read sets a sticky lost flag.
//
// Ports:
//   clock      in   single clock, all state updates on posedge
//   reset      in   synchronous, active-high
//   enable     in   1 = count windows, 0 = idle (partial window discarded)
//   evt        in   detection pulse, each high cycle is one event
//   alarm      out  registered one-cycle pulse when count reaches THRESH
//   rep_valid  out  report pending
//   rep_ready  in   consumer accepts report
//   rep_count  out  event count of the reported window (CW bits)
//   rep_lost   out  an earlier report was overwritten unread
module event_window_counter #(
  parameter int WINDOW = 8,
  parameter int THRESH = 3,
  parameter int CW     = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          evt,
  output logic          alarm,
  output logic          rep_valid,
  input  logic          rep_ready,
  output logic [CW-1:0] rep_count,
  output logic          rep_lost
);

  localparam int TW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(WINDOW - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] THR      = CW'(THRESH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_reg;
  logic [TW-1:0] tmr_reg;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] inc;
  logic          xfer;

  // Saturating count including this cycle's event.
  always_comb begin
    inc = cnt_reg;
    if (evt && (cnt_reg != CNT_MAX))
      inc = cnt_reg + CW'(1);
  end

  assign xfer = rep_valid && rep_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      tmr_reg   <= '0;
      cnt_reg   <= '0;
      alarm     <= 1'b0;
      rep_valid <= 1'b0;
      rep_count <= '0;
      rep_lost  <= 1'b0;
    end else begin
      alarm <= 1'b0;

      // A transfer consumes the pending report; a window close later in this
      // block may immediately load a new one.
      if (xfer) begin
        rep_valid <= 1'b0;
        rep_lost  <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          tmr_reg <= '0;
          cnt_reg <= '0;
          if (enable)
            state_reg <= RUN;
        end

        RUN: begin
          if (!enable) begin
            // Partial window is dropped silently; pending report is kept.
            state_reg <= IDLE;
            tmr_reg   <= '0;
            cnt_reg   <= '0;
          end else begin
            // Only the crossing edge fires, so saturation or later events
            // cannot retrigger within the window.
            alarm <= (cnt_reg < THR) && (inc == THR);
            if (tmr_reg == TMR_LAST) begin
              rep_count <= inc;
              rep_valid <= 1'b1;
              // Overwrite of an unread report is flagged; a same-edge
              // transfer means the old report was consumed, so no loss.
              rep_lost  <= rep_valid && !rep_ready;
              tmr_reg   <= '0;
              cnt_reg   <= '0;
            end else begin
              tmr_reg <= tmr_reg + TW'(1);
              cnt_reg <= inc;
            end
          end
        end

        default: begin
          state_reg <= IDLE;
          tmr_reg   <= '0;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_event_window_counter.sv
module tb_event_window_counter;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       evt;
  logic       rep_ready;

  logic       alarm, rep_valid, rep_lost;
  logic [3:0] rep_count;

  // Narrow-count instance sharing the same stimulus, used for saturation.
  logic       alarm3, rep_valid3, rep_lost3;
  logic [2:0] rep_count3;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  event_window_counter #(.WINDOW(8), .THRESH(3), .CW(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .evt      (evt),
    .alarm    (alarm),
    .rep_valid(rep_valid),
    .rep_ready(rep_ready),
    .rep_count(rep_count),
    .rep_lost (rep_lost)
  );

  event_window_counter #(.WINDOW(8), .THRESH(3), .CW(3)) dut3 (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .evt      (evt),
    .alarm    (alarm3),
    .rep_valid(rep_valid3),
    .rep_ready(rep_ready),
    .rep_count(rep_count3),
    .rep_lost (rep_lost3)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d @%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_report(input string tag, input int v, input int c, input int l);
    chk({tag, ".valid"}, int'(rep_valid), v);
    chk({tag, ".count"}, int'(rep_count), c);
    chk({tag, ".lost"},  int'(rep_lost),  l);
  endtask

  // Drives one full window of 8 RUN edges; ev/rdy give evt/rep_ready per
  // cycle. alarm_k is the cycle whose edge should raise alarm (-1 = none).
  task automatic run_window(input string tag, input logic [7:0] ev,
                            input logic [7:0] rdy, input int alarm_k);
    for (int k = 0; k < 8; k++) begin
      evt       = ev[k];
      rep_ready = rdy[k];
      tick();
      chk($sformatf("%s.alarm%0d", tag, k), int'(alarm), (k == alarm_k) ? 1 : 0);
      if (rdy[k] && k < 7) begin
        chk($sformatf("%s.xfer_valid%0d", tag, k), int'(rep_valid), 0);
        chk($sformatf("%s.xfer_lost%0d", tag, k),  int'(rep_lost),  0);
      end
    end
    evt       = 1'b0;
    rep_ready = 1'b0;
  endtask

  initial begin
    // 1: reset dominates enable/evt, then basic window
    reset = 1'b1; enable = 1'b1; evt = 1'b1; rep_ready = 1'b0;
    tick(); tick();
    chk("rst.alarm", int'(alarm), 0);
    chk_report("rst", 0, 0, 0);
    reset = 1'b0; evt = 1'b0;
    tick();                                   // IDLE -> RUN edge
    chk("t1.enter_alarm", int'(alarm), 0);
    run_window("t1", 8'b0010_1010, 8'h00, 5);
    chk_report("t1", 1, 3, 0);

    // 2: continuous events, ready consumes previous report at cycle 0
    for (int w = 0; w < 3; w++) begin
      run_window($sformatf("t2w%0d", w), 8'hFF, 8'h01, 2);
      chk_report($sformatf("t2w%0d", w), 1, 8, 0);
      chk($sformatf("t2w%0d.cw3_count", w), int'(rep_count3), 7);
      chk($sformatf("t2w%0d.cw3_valid", w), int'(rep_valid3), 1);
      chk($sformatf("t2w%0d.cw3_lost", w),  int'(rep_lost3),  0);
    end

    // 3: two closes without ready -> overwrite and lost
    run_window("t3a", 8'b0000_0011, 8'h01, -1);
    chk_report("t3a", 1, 2, 0);
    run_window("t3b", 8'b0001_1111, 8'h00, 2);
    chk_report("t3b", 1, 5, 1);

    // 4: ready on the closing edge with a pending (lost) report
    run_window("t4a", 8'b0000_0001, 8'h00, -1);
    chk_report("t4a", 1, 1, 1);
    run_window("t4b", 8'b0000_0110, 8'h80, -1);
    chk_report("t4b", 1, 2, 0);

    // 5: enable drops mid-window after 2 events
    for (int k = 0; k < 4; k++) begin
      evt = (k < 2);
      tick();
      chk($sformatf("t5p.alarm%0d", k), int'(alarm), 0);
    end
    enable = 1'b0; evt = 1'b0;
    tick();                                   // RUN -> IDLE
    chk_report("t5idle", 1, 2, 0);
    evt = 1'b1;
    tick(); tick();
    chk("t5idle.alarm", int'(alarm), 0);
    enable = 1'b1;                            // evt ignored on entry edge
    tick();
    chk_report("t5enter", 1, 2, 0);
    run_window("t5w", 8'b0000_0001, 8'h00, -1);
    chk_report("t5w", 1, 1, 1);
    run_window("t3c", 8'h00, 8'h01, -1);      // ready clears valid and lost
    chk_report("t3c", 1, 0, 0);

    // 6: reset mid-window with valid and lost set
    run_window("t6a", 8'h00, 8'h00, -1);
    chk_report("t6a", 1, 0, 1);
    evt = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("t6rst.alarm", int'(alarm), 0);
    chk_report("t6rst", 0, 0, 0);
    reset = 1'b0;
    tick();                                   // IDLE -> RUN, evt ignored
    chk("t6enter.alarm", int'(alarm), 0);
    chk("t6enter.valid", int'(rep_valid), 0);
    run_window("t6w", 8'b1000_0011, 8'h00, 7);
    chk_report("t6w", 1, 3, 0);
    tick();
    chk("t6post.alarm", int'(alarm), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
